// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: opcode constants and immediate format codes shared by the immediate generator
package imm_gen_pkg;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] MISC_MEM  = 7'b0001111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    typedef logic [2:0] fmt_t;

    localparam fmt_t FMT_R    = 3'd0;
    localparam fmt_t FMT_I    = 3'd1;
    localparam fmt_t FMT_S    = 3'd2;
    localparam fmt_t FMT_B    = 3'd3;
    localparam fmt_t FMT_U    = 3'd4;
    localparam fmt_t FMT_J    = 3'd5;
    localparam fmt_t FMT_SH   = 3'd6;
    localparam fmt_t FMT_NONE = 3'd7;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational opcode-to-format decode and immediate extraction
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);
    localparam logic RV64 = (XLEN == 64);

    logic [6:0]  op;
    logic [31:0] raw;
    logic [31:0] shamt;

    assign op    = instr[6:0];
    assign shamt = RV64 ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};

    // classify the opcode; OP_IMM shifts (funct3 001/101) carry a shift amount, not an immediate
    always_comb begin
        fmt = FMT_NONE;
        case (op)
            OP_IMM:              fmt = (instr[13:12] == 2'b01) ? FMT_SH : FMT_I;
            LOAD, JALR:          fmt = FMT_I;
            OP_IMM_32:           fmt = RV64 ? FMT_I : FMT_NONE;
            STORE:               fmt = FMT_S;
            BRANCH:              fmt = FMT_B;
            LUI, AUIPC:          fmt = FMT_U;
            JAL:                 fmt = FMT_J;
            OP, MISC_MEM, SYSTEM: fmt = FMT_R;
            OP_32:               fmt = RV64 ? FMT_R : FMT_NONE;
            default:             fmt = FMT_NONE;
        endcase
    end

    // 32-bit immediate first; shift amounts have a clear top bit so one sign extension serves all formats
    always_comb begin
        raw = (fmt == FMT_I)  ? {{20{instr[31]}}, instr[31:20]} :
              (fmt == FMT_SH) ? shamt :
              (fmt == FMT_S)  ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
              (fmt == FMT_B)  ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
              (fmt == FMT_U)  ? {instr[31:12], 12'b0} :
              (fmt == FMT_J)  ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
                                32'b0;
    end

    assign imm     = XLEN'($signed(raw));
    assign illegal = (fmt == FMT_NONE);
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a main output register and one skid entry
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);
    logic [XLEN-1:0]  dec_imm;
    fmt_t             dec_fmt;
    logic             dec_ill;
    logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    fmt_t             main_fmt_q, main_fmt_d, skid_fmt_q, skid_fmt_d;
    logic             main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
    logic             acc, can_load, from_skid, to_main, to_skid;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr  (in_instr),
        .imm    (dec_imm),
        .fmt    (dec_fmt),
        .illegal(dec_ill)
    );

    // in_ready comes straight from a flop so out_ready never reaches it combinationally;
    // while skid is occupied no input is taken, so skid->main and new->main never collide
    assign in_ready  = !skid_valid_q;
    assign acc       = in_valid && in_ready;
    assign can_load  = !main_valid_q || out_ready;
    assign from_skid = can_load && skid_valid_q;
    assign to_main   = can_load && acc;
    assign to_skid   = !can_load && acc;

    // next state of main and skid entries
    always_comb begin
        main_valid_d = can_load ? (skid_valid_q || acc) : main_valid_q;
        main_imm_d   = from_skid ? skid_imm_q : to_main ? dec_imm : main_imm_q;
        main_fmt_d   = from_skid ? skid_fmt_q : to_main ? dec_fmt : main_fmt_q;
        main_ill_d   = from_skid ? skid_ill_q : to_main ? dec_ill : main_ill_q;
        main_tag_d   = from_skid ? skid_tag_q : to_main ? in_tag  : main_tag_q;
        skid_valid_d = can_load ? 1'b0 : (skid_valid_q || acc);
        skid_imm_d   = to_skid ? dec_imm : skid_imm_q;
        skid_fmt_d   = to_skid ? dec_fmt : skid_fmt_q;
        skid_ill_d   = to_skid ? dec_ill : skid_ill_q;
        skid_tag_d   = to_skid ? in_tag  : skid_tag_q;
    end

    // state registers, fully cleared on reset so no in-flight entry survives
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_fmt_q   <= '0;
            main_ill_q   <= 1'b0;
            main_tag_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= '0;
            skid_ill_q   <= 1'b0;
            skid_tag_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_fmt_q   <= main_fmt_d;
            main_ill_q   <= main_ill_d;
            main_tag_q   <= main_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_ill_q   <= skid_ill_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_imm     = main_imm_q;
    assign out_fmt     = main_fmt_q;
    assign out_illegal = main_ill_q;
    assign out_tag     = main_tag_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for the 32-bit pipe plus directed checks on a 64-bit instance
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_tag = '0;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm, out_tag;
    logic [2:0]  out_fmt;

    logic        v64_in_valid = 1'b0;
    logic        v64_out_ready = 1'b1;
    logic [31:0] v64_in_instr = '0;
    logic [15:0] v64_in_tag = '0;
    logic        v64_in_ready, v64_out_valid, v64_out_illegal;
    logic [63:0] v64_out_imm;
    logic [2:0]  v64_out_fmt;
    logic [15:0] v64_out_tag;

    exp_t exp_cur;
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   n_pop = 0;

    logic [31:0] b_ins [4] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7};
    logic [31:0] b_imm [4] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000};
    logic [2:0]  b_fmt [4] = '{FMT_I, FMT_S, FMT_B, FMT_U};

    logic [31:0] f_ins [8] = '{32'h00309093, 32'h4030D093, 32'hFFDFF06F, 32'h0040A103,
                               32'h002081B3, 32'h0000003B, 32'h0000007F, 32'h00000017};
    logic [31:0] f_imm [8] = '{32'h3, 32'h3, 32'hFFFFFFFC, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [2:0]  f_fmt [8] = '{FMT_SH, FMT_SH, FMT_J, FMT_I, FMT_R, FMT_NONE, FMT_NONE, FMT_U};
    logic        f_ill [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] f_tag [8] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'hCAFE0000, 32'h2C};

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(16)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(v64_in_valid), .in_ready(v64_in_ready), .in_instr(v64_in_instr), .in_tag(v64_in_tag),
        .out_valid(v64_out_valid), .out_ready(v64_out_ready), .out_imm(v64_out_imm),
        .out_fmt(v64_out_fmt), .out_illegal(v64_out_illegal), .out_tag(v64_out_tag)
    );

    always #5 clk = ~clk;

    // scoreboard: pop on output transfer, push on input transfer, flush on reset
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL stale_output imm=%h tag=%h with nothing outstanding", out_imm, out_tag);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_pop++;
                    if ({out_imm, out_fmt, out_illegal, out_tag} !== e) begin
                        failures++;
                        $display("FAIL sb_entry got imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d ill=%b tag=%h",
                                 out_imm, out_fmt, out_illegal, out_tag, e.imm, e.fmt, e.ill, e.tag);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(exp_cur);
        end
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] tag,
                         input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
        exp_cur  = {imm, fmt, ill, tag};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, out_imm, out_fmt, out_illegal, out_tag} !== {1'b0, 1'b1, 32'b0, 3'b0, 1'b0, 32'b0}) begin
            failures++;
            $display("FAIL reset32 valid=%b ready=%b imm=%h fmt=%0d ill=%b tag=%h want 0/1/0/0/0/0",
                     out_valid, in_ready, out_imm, out_fmt, out_illegal, out_tag);
        end
        checks++;
        if ({v64_out_valid, v64_in_ready, v64_out_imm} !== {1'b0, 1'b1, 64'b0}) begin
            failures++;
            $display("FAIL reset64 valid=%b ready=%b imm=%h want 0/1/0", v64_out_valid, v64_in_ready, v64_out_imm);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 drive(b_ins[i], 32'h1000 + i, b_imm[i], b_fmt[i], 1'b0);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== (i != 0)) begin
                failures++;
                $display("FAIL b2b_cycle%0d ready=%b valid=%b want ready=1 valid=%b", i, in_ready, out_valid, i != 0);
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_last valid=%b want 1", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain valid=%b outstanding=%0d want 0/0", out_valid, sb.size());
        end
    endtask

    task automatic test_formats;
        int start;
        start = n_pop;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 drive(f_ins[i], f_tag[i], f_imm[i], f_fmt[i], f_ill[i]);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (n_pop - start != 8 || sb.size() != 0) begin
            failures++;
            $display("FAIL formats_count delivered=%0d outstanding=%0d want 8/0", n_pop - start, sb.size());
        end
    endtask

    task automatic test_backpressure;
        int idx;
        int low_at;
        int start;
        bit done;
        idx = 0;
        low_at = -1;
        start = n_pop;
        done = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1 drive(32'h00100093 + (idx << 20), 32'h100 + idx, idx + 1, FMT_I, 1'b0);
            @(negedge clk);
            if (in_ready === 1'b0 && low_at < 0) low_at = c;
            if (c >= 2) begin
                checks++;
                if (out_imm !== 32'h1 || out_tag !== 32'h100) begin
                    failures++;
                    $display("FAIL bp_hold imm=%h tag=%h want 1/100", out_imm, out_tag);
                end
            end
            if (in_valid && in_ready) idx++;
        end
        checks++;
        if (idx != 2 || low_at != 2) begin
            failures++;
            $display("FAIL bp_accept accepted=%0d ready_low_cycle=%0d want 2/2", idx, low_at);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_gap valid=%b want 1 delivered=%0d", out_valid, n_pop - start);
            end
            if (in_valid && in_ready) idx++;
            #1;
            if (n_pop - start == 4) done = 1;
            @(posedge clk);
            #1;
            if (idx < 4) drive(32'h00100093 + (idx << 20), 32'h100 + idx, idx + 1, FMT_I, 1'b0);
            else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (!done || sb.size() != 0) begin
            failures++;
            $display("FAIL bp_release delivered=%0d outstanding=%0d want 4/0", n_pop - start, sb.size());
        end
    endtask

    task automatic test_reset_mid;
        int start;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 drive(32'h00500093, 32'hDEAD0000 + i, 32'h5, FMT_I, 1'b0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_fill ready=%b valid=%b want 0/1", in_ready, out_valid);
        end
        rst = 1'b1;
        drive(32'h00600093, 32'hDEAD0002, 32'h6, FMT_I, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_imm, in_ready} !== {1'b0, 32'b0, 1'b1}) begin
            failures++;
            $display("FAIL rst_mid valid=%b imm=%h ready=%b want 0/0/1", out_valid, out_imm, in_ready);
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        start = n_pop;
        #1 drive(32'h00700093, 32'h77, 32'h7, FMT_I, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (n_pop - start != 1) begin
            failures++;
            $display("FAIL rst_resume delivered=%0d want 1", n_pop - start);
        end
    endtask

    task automatic test_xlen64;
        @(posedge clk);
        #1 v64_in_valid = 1'b1;
        v64_in_instr = 32'hFFF00093;
        v64_in_tag = 16'hA1;
        @(posedge clk);
        #1;
        checks++;
        if ({v64_out_valid, v64_out_imm, v64_out_fmt, v64_out_tag} !== {1'b1, 64'hFFFFFFFFFFFFFFFF, FMT_I, 16'hA1}) begin
            failures++;
            $display("FAIL x64_addi valid=%b imm=%h fmt=%0d tag=%h want 1/ffffffffffffffff/1/a1",
                     v64_out_valid, v64_out_imm, v64_out_fmt, v64_out_tag);
        end
        v64_in_instr = 32'h03F09093;
        v64_in_tag = 16'hA2;
        @(posedge clk);
        #1;
        checks++;
        if ({v64_out_valid, v64_out_imm, v64_out_fmt, v64_out_illegal} !== {1'b1, 64'd63, FMT_SH, 1'b0}) begin
            failures++;
            $display("FAIL x64_slli63 valid=%b imm=%h fmt=%0d ill=%b want 1/3f/6/0",
                     v64_out_valid, v64_out_imm, v64_out_fmt, v64_out_illegal);
        end
        v64_in_instr = 32'h0010009B;
        v64_in_tag = 16'hA3;
        @(posedge clk);
        #1 v64_in_valid = 1'b0;
        checks++;
        if ({v64_out_imm, v64_out_fmt, v64_out_illegal} !== {64'd1, FMT_I, 1'b0}) begin
            failures++;
            $display("FAIL x64_addiw imm=%h fmt=%0d ill=%b want 1/1/0", v64_out_imm, v64_out_fmt, v64_out_illegal);
        end
        @(posedge clk);
        #1;
        checks++;
        if (v64_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL x64_idle valid=%b want 0", v64_out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_formats();
        test_backpressure();
        test_reset_mid();
        test_xlen64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
